draw_rect_ctl: RTL and testbench

DRAW_RECT_CTL -- requirements
Module: draw_rect_ctl

---
 rtl/vga_pkg.sv | 14 +
 rtl/edge_det.sv | 25 ++
 rtl/draw_rect_ctl.sv | 106 ++++++++++
 tb/tb_draw_rect_ctl.sv | 124 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the rectangle-controller state type.
package vga_pkg;

  localparam int unsigned HOR_PIXELS = 800;
  localparam int unsigned VER_PIXELS = 600;

  typedef enum logic [1:0] {
    IDLE,
    FALL,
    RISE,
    STOP
  } rect_ctl_state_t;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector: one-cycle pulse when sig goes high, never on a level held through reset.
module edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic sig_q;
  logic armed;

  // armed stays low for the first cycle after reset so a level already high is absorbed, not pulsed
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q <= 1'b0;
      armed <= 1'b0;
    end else begin
      sig_q <= sig;
      armed <= 1'b1;
    end
  end

  assign pulse = armed & sig & ~sig_q;

endmodule

// File: rtl/draw_rect_ctl.sv
// Bouncing-rectangle controller: tracks the mouse until clicked, then drops the
// rectangle under gravity with damped floor bounces, one step per frame tick.
module draw_rect_ctl
  import vga_pkg::*;
#(
  parameter int unsigned RECT_H  = 100,
  parameter int unsigned GRAV    = 1,
  parameter int unsigned DAMP_SH = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        vblnk,
  input  logic [11:0] mouse_xpos,
  input  logic [11:0] mouse_ypos,
  input  logic        mouse_left,
  output logic [11:0] xpos_rect,
  output logic [11:0] ypos_rect
);

  localparam logic [11:0] YMAX   = 12'(VER_PIXELS - RECT_H);
  localparam logic [11:0] GRAV_V = 12'(GRAV);

  rect_ctl_state_t state;
  logic [11:0]     vel;
  logic            tick;
  logic            click;

  edge_det u_tick_det (
    .clk   (clk),
    .rst   (rst),
    .sig   (vblnk),
    .pulse (tick)
  );

  edge_det u_click_det (
    .clk   (clk),
    .rst   (rst),
    .sig   (mouse_left),
    .pulse (click)
  );

  logic [12:0] y_nxt;
  logic [12:0] vel_sum;
  logic [11:0] vel_inc;
  logic [11:0] vel_damp;
  logic [11:0] y_up;
  logic [11:0] y_track;

  always_comb begin
    y_nxt    = {1'b0, ypos_rect} + {1'b0, vel};
    vel_sum  = {1'b0, vel} + {1'b0, GRAV_V};
    vel_inc  = vel_sum[12] ? '1 : vel_sum[11:0];
    vel_damp = vel >> DAMP_SH;
    y_up     = (vel > ypos_rect) ? '0 : ypos_rect - vel;
    y_track  = (mouse_ypos > YMAX) ? YMAX : mouse_ypos;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      xpos_rect <= '0;
      ypos_rect <= '0;
      vel       <= '0;
    end else begin
      case (state)
        IDLE: begin
          vel <= '0;
          if (click) begin
            state <= FALL;
          end else begin
            xpos_rect <= mouse_xpos;
            ypos_rect <= y_track;
          end
        end
        FALL: begin
          if (tick) begin
            if (y_nxt < {1'b0, YMAX}) begin
              ypos_rect <= y_nxt[11:0];
              vel       <= vel_inc;
            end else begin
              ypos_rect <= YMAX;
              vel       <= vel_damp;
              state     <= (vel_damp != '0) ? RISE : STOP;
            end
          end
        end
        RISE: begin
          if (tick) begin
            if (vel <= GRAV_V) begin
              vel   <= '0;
              state <= FALL;
            end else begin
              ypos_rect <= y_up;
              vel       <= vel - GRAV_V;
            end
          end
        end
        STOP: begin
          if (click) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_draw_rect_ctl.sv
// Scoreboard bench for draw_rect_ctl: directed stimulus queues expected positions, a monitor checks them.
module tb_draw_rect_ctl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        vblnk = 1'b0;
  logic        mouse_left = 1'b0;
  logic [11:0] mouse_xpos = '0;
  logic [11:0] mouse_ypos = '0;
  logic [11:0] xpos_rect;
  logic [11:0] ypos_rect;

  draw_rect_ctl #(.RECT_H(100), .GRAV(1), .DAMP_SH(1)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .vblnk      (vblnk),
    .mouse_xpos (mouse_xpos),
    .mouse_ypos (mouse_ypos),
    .mouse_left (mouse_left),
    .xpos_rect  (xpos_rect),
    .ypos_rect  (ypos_rect)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    logic [11:0] x;
    logic [11:0] y;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // hand-derived drop from y=490, vel=0: four falls, bounce (vel 2), rise, settle at the floor
  logic [11:0] traj [12] = '{12'd490, 12'd491, 12'd493, 12'd496, 12'd500, 12'd498,
                             12'd498, 12'd498, 12'd499, 12'd500, 12'd500, 12'd500};

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (xpos_rect !== e.x || ypos_rect !== e.y) begin
          errors++;
          $display("FAIL %s: got (%0d,%0d) expected (%0d,%0d)",
                   e.nm, xpos_rect, ypos_rect, e.x, e.y);
        end
      end
    end
  end

  task automatic drive(input logic rs, input logic vb, input logic ml,
                       input logic [11:0] mx, input logic [11:0] my,
                       input logic [11:0] ex, input logic [11:0] ey, input string nm);
    exp_t e;
    @(negedge clk);
    rst        = rs;
    vblnk      = vb;
    mouse_left = ml;
    mouse_xpos = mx;
    mouse_ypos = my;
    e.nm = nm;
    e.x  = ex;
    e.y  = ey;
    q.push_back(e);
  endtask

  task automatic drop(input logic [11:0] x, input int click_at, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b1, 1'b0, mouse_xpos, mouse_ypos, x, traj[i], $sformatf("tick%0d", i));
      drive(1'b1, 1'b0, (i == click_at), mouse_xpos, mouse_ypos, x, traj[i],
            $sformatf("tick%0d_lo", i));
    end
  endtask

  initial begin : stim
    drive(1'b0, 1'b1, 1'b1, 12'd300, 12'd200, 12'd0,   12'd0,   "reset_hold");
    drive(1'b0, 1'b1, 1'b1, 12'd300, 12'd200, 12'd0,   12'd0,   "reset_hold2");
    drive(1'b1, 1'b1, 1'b1, 12'd300, 12'd200, 12'd300, 12'd200, "release");
    drive(1'b1, 1'b1, 1'b1, 12'd310, 12'd210, 12'd310, 12'd210, "no_spurious_click");
    drive(1'b1, 1'b0, 1'b0, 12'd310, 12'd550, 12'd310, 12'd500, "clamp");
    drive(1'b1, 1'b0, 1'b0, 12'd100, 12'd490, 12'd100, 12'd490, "track");
    drive(1'b1, 1'b0, 1'b1, 12'd100, 12'd490, 12'd100, 12'd490, "click");
    drive(1'b1, 1'b0, 1'b0, 12'd50,  12'd100, 12'd100, 12'd490, "frozen");
    drop(12'd100, -1, 12);
    drive(1'b1, 1'b0, 1'b0, 12'd50,  12'd100, 12'd100, 12'd500, "stop_hold");
    drive(1'b1, 1'b1, 1'b0, 12'd50,  12'd100, 12'd100, 12'd500, "stop_tick");
    drive(1'b1, 1'b0, 1'b0, 12'd50,  12'd100, 12'd100, 12'd500, "stop_tick_lo");
    drive(1'b1, 1'b0, 1'b1, 12'd50,  12'd100, 12'd100, 12'd500, "stop_click");
    drive(1'b1, 1'b0, 1'b0, 12'd50,  12'd100, 12'd50,  12'd100, "return");

    drive(1'b1, 1'b0, 1'b0, 12'd100, 12'd490, 12'd100, 12'd490, "track2");
    drive(1'b1, 1'b0, 1'b1, 12'd100, 12'd490, 12'd100, 12'd490, "click2");
    drive(1'b1, 1'b0, 1'b0, 12'd100, 12'd490, 12'd100, 12'd490, "fall2");
    drop(12'd100, 2, 12);
    drive(1'b1, 1'b0, 1'b0, 12'd100, 12'd490, 12'd100, 12'd500, "stop2");
    drive(1'b1, 1'b0, 1'b1, 12'd100, 12'd490, 12'd100, 12'd500, "stop_click2");
    drive(1'b1, 1'b0, 1'b0, 12'd100, 12'd490, 12'd100, 12'd490, "return2");

    drive(1'b1, 1'b0, 1'b1, 12'd100, 12'd490, 12'd100, 12'd490, "click3");
    drive(1'b1, 1'b0, 1'b0, 12'd100, 12'd490, 12'd100, 12'd490, "fall3");
    drop(12'd100, -1, 6);
    drive(1'b0, 1'b0, 1'b0, 12'd100, 12'd490, 12'd0,   12'd0,   "reset_rise");
    drive(1'b1, 1'b0, 1'b0, 12'd100, 12'd490, 12'd100, 12'd490, "release2");
    drive(1'b1, 1'b1, 1'b1, 12'd100, 12'd490, 12'd100, 12'd490, "tick_click");
    drive(1'b1, 1'b0, 1'b0, 12'd100, 12'd490, 12'd100, 12'd490, "tick_click_lo");
    drop(12'd100, -1, 4);

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
